// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// nn_pkg : shared Q4.4 constants, trainer state encoding and saturating add
// Revision: 1.0
// ============================================================================
package nn_pkg;

    localparam int FX_ONE   = 16;
    localparam int FX_SHIFT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } trainer_state_t;

    // Adds d to a and clamps the result to the signed range of a width-bit word.
    function automatic longint sat_add(input longint a, input longint d, input int width);
        longint hi;
        longint lo;
        longint s;
        hi = (longint'(1) <<< (width - 1)) - longint'(1);
        lo = -(longint'(1) <<< (width - 1));
        s  = a + d;
        if (s > hi) begin
            sat_add = hi;
        end else if (s < lo) begin
            sat_add = lo;
        end else begin
            sat_add = s;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/activation_step.sv
`default_nettype none
// ============================================================================
// activation_step : step activation, y = 1 when the signed input is >= 0
// Revision: 1.0
// ============================================================================
module activation_step #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] x,
    output logic                    y
);

    localparam logic signed [WIDTH-1:0] ZERO = '0;

    assign y = (x >= ZERO);

endmodule
`default_nettype wire

// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
// perceptron_trainer : online perceptron-rule trainer for a 2-input step neuron
// Revision: 1.0
// ============================================================================
module perceptron_trainer
    import nn_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LR         = FX_ONE / 2,
    parameter int INIT_W1    = 0,
    parameter int INIT_W2    = 0,
    parameter int INIT_B     = 0,
    parameter int N_SAMPLES  = 4,
    parameter int MAX_EPOCHS = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic                                 s_x1,
    input  logic                                 s_x2,
    input  logic                                 s_target,
    output logic signed [WIDTH-1:0]              w1,
    output logic signed [WIDTH-1:0]              w2,
    output logic signed [WIDTH-1:0]              b,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 converged,
    output logic [7:0]                           epoch_count,
    output logic [$clog2(N_SAMPLES+1)-1:0]       err_count
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    localparam logic signed [WIDTH-1:0]   INIT_W1_V  = WIDTH'(INIT_W1);
    localparam logic signed [WIDTH-1:0]   INIT_W2_V  = WIDTH'(INIT_W2);
    localparam logic signed [WIDTH-1:0]   INIT_B_V   = WIDTH'(INIT_B);
    localparam logic signed [WIDTH+1:0]   ZERO_EXT   = '0;
    localparam logic [CNT_W-1:0]          LAST_IDX   = CNT_W'(N_SAMPLES - 1);
    localparam logic [7:0]                LAST_EPOCH = 8'(MAX_EPOCHS - 1);

    trainer_state_t          state;
    logic [CNT_W-1:0]        idx;
    logic                    x1_q;
    logic                    x2_q;
    logic                    tgt_q;

    logic signed [WIDTH+1:0] w1_ext;
    logic signed [WIDTH+1:0] w2_ext;
    logic signed [WIDTH+1:0] b_ext;
    logic signed [WIDTH+1:0] sum;
    logic                    y;
    logic                    err_pos;
    logic                    err_neg;
    logic                    err_any;
    longint                  delta;
    logic signed [WIDTH-1:0] w1_next;
    logic signed [WIDTH-1:0] w2_next;
    logic signed [WIDTH-1:0] b_next;
    logic [CNT_W-1:0]        err_total;

    // Two guard bits keep the three-term sum exact for any weight values.
    assign w1_ext = {{2{w1[WIDTH-1]}}, w1};
    assign w2_ext = {{2{w2[WIDTH-1]}}, w2};
    assign b_ext  = {{2{b[WIDTH-1]}}, b};
    assign sum    = (x1_q ? w1_ext : ZERO_EXT) + (x2_q ? w2_ext : ZERO_EXT) + b_ext;

    activation_step #(
        .WIDTH (WIDTH + 2)
    ) u_step (
        .x (sum),
        .y (y)
    );

    always_comb begin
        err_pos   = tgt_q & ~y;
        err_neg   = ~tgt_q & y;
        err_any   = err_pos | err_neg;
        delta     = err_pos ? longint'(LR) : -longint'(LR);
        w1_next   = w1;
        w2_next   = w2;
        b_next    = b;
        if (err_any) begin
            b_next = WIDTH'(sat_add(longint'(b), delta, WIDTH));
            if (x1_q) begin
                w1_next = WIDTH'(sat_add(longint'(w1), delta, WIDTH));
            end
            if (x2_q) begin
                w2_next = WIDTH'(sat_add(longint'(w2), delta, WIDTH));
            end
        end
        err_total = err_count + CNT_W'(err_any);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            w1          <= INIT_W1_V;
            w2          <= INIT_W2_V;
            b           <= INIT_B_V;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            epoch_count <= 8'd0;
            err_count   <= '0;
            idx         <= '0;
            x1_q        <= 1'b0;
            x2_q        <= 1'b0;
            tgt_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w1          <= INIT_W1_V;
                        w2          <= INIT_W2_V;
                        b           <= INIT_B_V;
                        epoch_count <= 8'd0;
                        err_count   <= '0;
                        converged   <= 1'b0;
                        idx         <= '0;
                        state       <= ST_TRAIN;
                        s_ready     <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                ST_TRAIN: begin
                    if (s_valid && s_ready) begin
                        x1_q    <= s_x1;
                        x2_q    <= s_x2;
                        tgt_q   <= s_target;
                        state   <= ST_UPDATE;
                        s_ready <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    w1        <= w1_next;
                    w2        <= w2_next;
                    b         <= b_next;
                    err_count <= err_total;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        epoch_count <= epoch_count + 8'd1;
                        if (err_total == '0) begin
                            converged <= 1'b1;
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (epoch_count == LAST_EPOCH) begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            err_count <= '0;
                            state     <= ST_TRAIN;
                            s_ready   <= 1'b1;
                        end
                    end else begin
                        idx     <= idx + CNT_W'(1);
                        state   <= ST_TRAIN;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
